// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller: opcodes, FSM states,
// forwarding selects and the source-register usage decode.
package hazard_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_LOAD_WAIT,
        HZ_MC_BUSY
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_IDEX = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    // Returns {rs2_used, rs1_used}; LUI, AUIPC, JAL and unknown opcodes read nothing.
    function automatic logic [1:0] rs_used(input logic [6:0] opcode);
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: rs_used = 2'b11;
            OP_I, OP_LOAD, OP_JALR:    rs_used = 2'b01;
            default:                   rs_used = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Operand forwarding selector for one EX source: MEM result wins over WB, x0 never forwards.
module hazard_fwd_mux_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rd_wren_mem,
    input  logic [REG_AW-1:0] rd_addr_mem,
    input  logic              rd_wren_wb,
    input  logic [REG_AW-1:0] rd_addr_wb,
    output logic [1:0]        fwd_sel
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_IDEX;
        if (rs_addr != '0) begin
            if (rd_wren_mem && (rd_addr_mem == rs_addr)) begin
                sel = FWD_MEM;
            end else if (rd_wren_wb && (rd_addr_wb == rs_addr)) begin
                sel = FWD_WB;
            end
        end
    end

    assign fwd_sel = sel;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard and forwarding controller: load-use stalls, multi-cycle EX freeze with watchdog,
// mispredict flush. Optional performance counters under HAZARD_PERF_EN.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int MC_MAX_CYC     = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_instr_id,
    input  logic [REG_AW-1:0] i_rs1_addr_id,
    input  logic [REG_AW-1:0] i_rs2_addr_id,
    input  logic              i_mem_ren_ex,
    input  logic [REG_AW-1:0] i_rd_addr_ex,
    input  logic [REG_AW-1:0] i_rs1_addr_ex,
    input  logic [REG_AW-1:0] i_rs2_addr_ex,
    input  logic              i_rd_wren_mem,
    input  logic [REG_AW-1:0] i_rd_addr_mem,
    input  logic              i_rd_wren_wb,
    input  logic [REG_AW-1:0] i_rd_addr_wb,
    input  logic              i_mc_start,
    input  logic              i_mc_done,
    input  logic              i_mispredict,
    output logic              o_stall_pc,
    output logic              o_stall_if_id,
    output logic              o_stall_id_ex,
    output logic              o_flush_if_id,
    output logic              o_flush_id_ex,
    output logic              o_flush_ex_mem,
    output logic [1:0]        o_forward_a,
    output logic [1:0]        o_forward_b,
    output logic              o_mc_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
`endif
);

    localparam int          WD_W          = $clog2(MC_MAX_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(MC_MAX_CYC);
    localparam logic [1:0]  LOAD_CNT_INIT = 2'(LOAD_STALL_CYC - 1);

    hz_state_e        state_reg, state_next;
    logic [1:0]       cnt_reg, cnt_next;
    logic [WD_W-1:0]  wd_reg, wd_next;

    logic stall_front, stall_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic mc_timeout, mispredict_acc;
    logic load_use;
    logic [1:0] used;
    logic unused_instr_bits;

    assign unused_instr_bits = ^i_instr_id[31:7];

    // Forwarding is independent of FSM state: one selector per EX source operand.
    logic [REG_AW-1:0] rs_ex [2];
    logic [1:0]        fwd_sel [2];
    assign rs_ex[0] = i_rs1_addr_ex;
    assign rs_ex[1] = i_rs2_addr_ex;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_fwd_mux_sel #(.REG_AW(REG_AW)) u_sel (
                .rs_addr     (rs_ex[gi]),
                .rd_wren_mem (i_rd_wren_mem),
                .rd_addr_mem (i_rd_addr_mem),
                .rd_wren_wb  (i_rd_wren_wb),
                .rd_addr_wb  (i_rd_addr_wb),
                .fwd_sel     (fwd_sel[gi])
            );
        end
    endgenerate

    assign o_forward_a = fwd_sel[0];
    assign o_forward_b = fwd_sel[1];

    assign used     = rs_used(i_instr_id[6:0]);
    assign load_use = i_mem_ren_ex && (i_rd_addr_ex != '0) &&
                      ((used[0] && (i_rs1_addr_id == i_rd_addr_ex)) ||
                       (used[1] && (i_rs2_addr_id == i_rd_addr_ex)));

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        wd_next        = wd_reg;
        stall_front    = 1'b0;
        stall_ex       = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        flush_ex_mem   = 1'b0;
        mc_timeout     = 1'b0;
        mispredict_acc = 1'b0;
        case (state_reg)
            HZ_RUN: begin
                if (i_mispredict) begin
                    flush_if_id    = 1'b1;
                    flush_id_ex    = 1'b1;
                    mispredict_acc = 1'b1;
                end else if (i_mc_start) begin
                    // A single-cycle op (done with start) never freezes the pipe.
                    if (!i_mc_done) begin
                        stall_front  = 1'b1;
                        stall_ex     = 1'b1;
                        flush_ex_mem = 1'b1;
                        wd_next      = WD_W'(1);
                        state_next   = HZ_MC_BUSY;
                    end
                end else if (load_use) begin
                    stall_front = 1'b1;
                    flush_id_ex = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        cnt_next   = LOAD_CNT_INIT;
                        state_next = HZ_LOAD_WAIT;
                    end
                end
            end
            HZ_LOAD_WAIT: begin
                stall_front = 1'b1;
                flush_id_ex = 1'b1;
                if (cnt_reg <= 2'd1) begin
                    state_next = HZ_RUN;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            HZ_MC_BUSY: begin
                // wd_reg counts busy cycles already spent, including the start cycle.
                if (i_mc_done) begin
                    state_next = HZ_RUN;
                end else if (wd_reg >= WD_MAX) begin
                    mc_timeout = 1'b1;
                    state_next = HZ_RUN;
                end else begin
                    stall_front  = 1'b1;
                    stall_ex     = 1'b1;
                    flush_ex_mem = 1'b1;
                    wd_next      = wd_reg + WD_W'(1);
                end
            end
            default: state_next = HZ_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= HZ_RUN;
            cnt_reg   <= '0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wd_reg    <= wd_next;
        end
    end

    assign o_stall_pc     = stall_front & ~i_reset;
    assign o_stall_if_id  = stall_front & ~i_reset;
    assign o_stall_id_ex  = stall_ex & ~i_reset;
    assign o_flush_if_id  = flush_if_id & ~i_reset;
    assign o_flush_id_ex  = flush_id_ex & ~i_reset;
    assign o_flush_ex_mem = flush_ex_mem & ~i_reset;
    assign o_mc_timeout   = mc_timeout & ~i_reset;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (o_stall_pc) stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (mispredict_acc) flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
    assign o_flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit (LOAD_STALL_CYC=2, MC_MAX_CYC=8); perf
// counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_id;
    logic [4:0]  rs1_id, rs2_id, rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb;
    logic        ren_ex, wren_mem, wren_wb, mc_start, mc_done, mispredict;
    logic        stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  fwd_a, fwd_b;
    logic        mc_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_AW(5), .LOAD_STALL_CYC(2), .MC_MAX_CYC(8)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_instr_id     (instr_id),
        .i_rs1_addr_id  (rs1_id),
        .i_rs2_addr_id  (rs2_id),
        .i_mem_ren_ex   (ren_ex),
        .i_rd_addr_ex   (rd_ex),
        .i_rs1_addr_ex  (rs1_ex),
        .i_rs2_addr_ex  (rs2_ex),
        .i_rd_wren_mem  (wren_mem),
        .i_rd_addr_mem  (rd_mem),
        .i_rd_wren_wb   (wren_wb),
        .i_rd_addr_wb   (rd_wb),
        .i_mc_start     (mc_start),
        .i_mc_done      (mc_done),
        .i_mispredict   (mispredict),
        .o_stall_pc     (stall_pc),
        .o_stall_if_id  (stall_if_id),
        .o_stall_id_ex  (stall_id_ex),
        .o_flush_if_id  (flush_if_id),
        .o_flush_id_ex  (flush_id_ex),
        .o_flush_ex_mem (flush_ex_mem),
        .o_forward_a    (fwd_a),
        .o_forward_b    (fwd_b),
        .o_mc_timeout   (mc_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [4:0] rs1_id, rs2_id;
        logic       ren;
        logic [4:0] rd_ex, rs1_ex, rs2_ex;
        logic       wm;
        logic [4:0] rdm;
        logic       ww;
        logic [4:0] rdw;
        logic       mis;
        logic       stall, fif, fid;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mkv(input string n, input logic [6:0] op,
                                 input logic [4:0] r1i, input logic [4:0] r2i,
                                 input logic ren, input logic [4:0] rdx,
                                 input logic [4:0] r1x, input logic [4:0] r2x,
                                 input logic wm, input logic [4:0] rdm,
                                 input logic ww, input logic [4:0] rdw,
                                 input logic mis, input logic st, input logic fif,
                                 input logic fid, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.name = n; v.op = op; v.rs1_id = r1i; v.rs2_id = r2i; v.ren = ren;
        v.rd_ex = rdx; v.rs1_ex = r1x; v.rs2_ex = r2x; v.wm = wm; v.rdm = rdm;
        v.ww = ww; v.rdw = rdw; v.mis = mis; v.stall = st; v.fif = fif; v.fid = fid;
        v.fa = fa; v.fb = fb;
        return v;
    endfunction

    // Bundle order: stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
    // flush_ex_mem, forward_a, forward_b, mc_timeout.
    function automatic logic [10:0] outs();
        return {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
                flush_ex_mem, fwd_a, fwd_b, mc_timeout};
    endfunction

    function automatic logic [10:0] e(input logic sf, input logic sx, input logic fif,
                                      input logic fid, input logic fem, input logic to);
        return {sf, sf, sx, fif, fid, fem, 4'b0000, to};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic clear_inputs();
        instr_id = '0; rs1_id = '0; rs2_id = '0; ren_ex = 1'b0; rd_ex = '0;
        rs1_ex = '0; rs2_ex = '0; wren_mem = 1'b0; rd_mem = '0; wren_wb = 1'b0;
        rd_wb = '0; mc_start = 1'b0; mc_done = 1'b0; mispredict = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        instr_id = 32'h00138433; // add x8, x7, x1
        rs1_id = 5'd7; rs2_id = 5'd1; ren_ex = 1'b1; rd_ex = 5'd7;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mkv("fwd_mem_over_wb", 7'b0110011, 0, 0, 0, 0, 5, 0, 1, 5, 1, 5, 0, 0, 0, 0, 2'b01, 2'b00);
        vecs[1]  = mkv("fwd_wb_only",     7'b0110011, 0, 0, 0, 0, 5, 0, 0, 5, 1, 5, 0, 0, 0, 0, 2'b10, 2'b00);
        vecs[2]  = mkv("fwd_x0",          7'b0110011, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        vecs[3]  = mkv("fwd_split",       7'b0110011, 0, 0, 0, 0, 3, 9, 1, 3, 1, 9, 0, 0, 0, 0, 2'b01, 2'b10);
        vecs[4]  = mkv("fwd_both_mem",    7'b0110011, 0, 0, 0, 0, 4, 4, 1, 4, 0, 4, 0, 0, 0, 0, 2'b01, 2'b01);
        vecs[5]  = mkv("lu_r_rs1",        7'b0110011, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[6]  = mkv("lu_r_rs2",        7'b0110011, 2, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[7]  = mkv("lu_lui",          7'b0110111, 7, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        vecs[8]  = mkv("lu_ialu_rs2",     7'b0010011, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        vecs[9]  = mkv("lu_ialu_rs1",     7'b0010011, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[10] = mkv("lu_store_rs2",    7'b0100011, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[11] = mkv("lu_branch_rs2",   7'b1100011, 2, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[12] = mkv("lu_jalr_rs2",     7'b1100111, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        vecs[13] = mkv("lu_load_rs1",     7'b0000011, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[14] = mkv("lu_jal",          7'b1101111, 7, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        vecs[15] = mkv("lu_x0",           7'b0110011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        vecs[16] = mkv("lu_not_load",     7'b0110011, 7, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        vecs[17] = mkv("misp_over_lu",    7'b0110011, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00, 2'b00);
        vecs[18] = mkv("lu_unknown_op",   7'b1111111, 7, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #2 check("reset_outputs", outs(), 11'b0);
`ifdef HAZARD_PERF_EN
        check32("reset_stall_cnt", stall_cnt, 32'd0);
        check32("reset_flush_cnt", flush_cnt, 32'd0);
`endif

        // Single-cycle vectors from RUN; an idle cycle afterwards drains any LOAD_WAIT.
        for (int i = 0; i < 19; i++) begin
            next_cycle();
            instr_id = {25'h0, vecs[i].op};
            rs1_id = vecs[i].rs1_id; rs2_id = vecs[i].rs2_id; ren_ex = vecs[i].ren;
            rd_ex = vecs[i].rd_ex; rs1_ex = vecs[i].rs1_ex; rs2_ex = vecs[i].rs2_ex;
            wren_mem = vecs[i].wm; rd_mem = vecs[i].rdm; wren_wb = vecs[i].ww;
            rd_wb = vecs[i].rdw; mispredict = vecs[i].mis;
            #2 check(vecs[i].name, outs(),
                     {vecs[i].stall, vecs[i].stall, 1'b0, vecs[i].fif, vecs[i].fid,
                      1'b0, vecs[i].fa, vecs[i].fb, 1'b0});
            next_cycle();
            clear_inputs();
            next_cycle();
            clear_inputs();
        end

        // Load-use costs exactly two bubbles, then releases.
        next_cycle(); set_load_use();
        #2 check("lu_seq_cyc1", outs(), e(1, 0, 0, 1, 0, 0));
        next_cycle();
        #2 check("lu_seq_cyc2", outs(), e(1, 0, 0, 1, 0, 0));
        next_cycle(); ren_ex = 1'b0;
        #2 check("lu_seq_release", outs(), e(0, 0, 0, 0, 0, 0));
        next_cycle(); clear_inputs(); instr_id = 32'h000003b7; rs1_id = 5'd7; rs2_id = 5'd7;
        ren_ex = 1'b1; rd_ex = 5'd7;
        #2 check("lu_seq_lui", outs(), e(0, 0, 0, 0, 0, 0));
        next_cycle(); clear_inputs();

        // Multi-cycle op with done in cycle 5; mispredict during busy is ignored.
        next_cycle(); mc_start = 1'b1;
        #2 check("mc_cyc1", outs(), e(1, 1, 0, 0, 1, 0));
        for (int c = 2; c <= 4; c++) begin
            next_cycle(); mc_start = 1'b0; mispredict = (c == 3);
            #2 check($sformatf("mc_cyc%0d", c), outs(), e(1, 1, 0, 0, 1, 0));
        end
        next_cycle(); mispredict = 1'b0; mc_done = 1'b1;
        #2 check("mc_cyc5_done", outs(), e(0, 0, 0, 0, 0, 0));
        next_cycle(); mc_done = 1'b0; mispredict = 1'b1;
        #2 check("mc_back_in_run", outs(), e(0, 0, 1, 1, 0, 0));
        next_cycle(); clear_inputs();

        // Start and done together: no freeze.
        next_cycle(); mc_start = 1'b1; mc_done = 1'b1;
        #2 check("mc_same_cycle_done", outs(), e(0, 0, 0, 0, 0, 0));
        next_cycle(); clear_inputs();
        #2 check("mc_same_cycle_after", outs(), e(0, 0, 0, 0, 0, 0));

        // Watchdog: 8 stalled busy cycles, then a forced-release pulse.
        next_cycle(); mc_start = 1'b1;
        #2 check("wd_cyc1", outs(), e(1, 1, 0, 0, 1, 0));
        for (int c = 2; c <= 8; c++) begin
            next_cycle(); mc_start = 1'b0;
            #2 check($sformatf("wd_cyc%0d", c), outs(), e(1, 1, 0, 0, 1, 0));
        end
        next_cycle();
        #2 check("wd_timeout_pulse", outs(), e(0, 0, 0, 0, 0, 1));
        next_cycle();
        #2 check("wd_after_pulse", outs(), e(0, 0, 0, 0, 0, 0));

        // MC start beats a simultaneous load-use; the hazard is re-detected afterwards.
        next_cycle(); set_load_use(); mc_start = 1'b1;
        #2 check("mc_beats_lu", outs(), e(1, 1, 0, 0, 1, 0));
        next_cycle(); mc_start = 1'b0; mc_done = 1'b1;
        #2 check("mc_beats_lu_done", outs(), e(0, 0, 0, 0, 0, 0));
        next_cycle(); mc_done = 1'b0;
        #2 check("lu_redetected", outs(), e(1, 0, 0, 1, 0, 0));
        next_cycle(); clear_inputs();
        #2 check("lu_redetected_wait", outs(), e(1, 0, 0, 1, 0, 0));
        next_cycle();
        #2 check("lu_redetected_done", outs(), e(0, 0, 0, 0, 0, 0));

        // Reset in the middle of LOAD_WAIT.
        next_cycle(); set_load_use();
        #2 check("rst_lw_enter", outs(), e(1, 0, 0, 1, 0, 0));
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0; clear_inputs();
        #2 check("rst_lw_after", outs(), e(0, 0, 0, 0, 0, 0));
`ifdef HAZARD_PERF_EN
        check32("rst_lw_stall_cnt", stall_cnt, 32'd0);
        next_cycle(); set_load_use();
        next_cycle();
        next_cycle(); clear_inputs(); mispredict = 1'b1;
        next_cycle(); mispredict = 1'b0;
        #2 check32("perf_stall_cnt", stall_cnt, 32'd2);
        check32("perf_flush_cnt", flush_cnt, 32'd1);
`endif

        // Reset in the middle of MC_BUSY, then prove RUN with a mispredict.
        next_cycle(); clear_inputs(); mc_start = 1'b1;
        next_cycle(); mc_start = 1'b0;
        #2 check("rst_mc_busy", outs(), e(1, 1, 0, 0, 1, 0));
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        #2 check("rst_mc_after", outs(), e(0, 0, 0, 0, 0, 0));
        next_cycle(); mispredict = 1'b1;
        #2 check("rst_mc_run", outs(), e(0, 0, 1, 1, 0, 0));
        next_cycle(); clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
